pipe_mem_arbiter: RTL

Arbitrates a single shared, variable-latency memory port between the processor's instruction-fetch stage (IF) and memory-writeback stage (MW, loads/stores). It sits between the pipeline and a unified memory. It serialises accesses and returns per-requester completion pulses and stall signals, which the pipeline uses to hold the PC and the pipeline buffers. Data accesses have priority, with a bounded-starvation guarantee for fetch and a watchdog that aborts hung transactions.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/arb_watchdog.sv | 30 +++
 rtl/pipe_mem_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the pipeline memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DATA} arb_state_e;

    typedef enum logic {OWN_IF, OWN_DM} arb_owner_e;

    localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/arb_watchdog.sv
// Counts busy cycles of the shared memory port; flags expiry on the
// TIMEOUT-th busy cycle so the owner can be released.
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_limit;

    assign w_at_limit = (r_cnt == CW'(TIMEOUT - 1));
    assign o_expire   = i_en && w_at_limit;

    // Holds at the limit rather than wrapping; the arbiter leaves the busy state anyway.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_limit) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and
// data access: data has priority, fetch is forced after STARVE_LIMIT data grants.
module pipe_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mw,
    output logic        bus_err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e  r_state;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [SW-1:0] r_starve;

    arb_owner_e  w_owner;
    logic        w_busy;
    logic        w_starved;
    logic        w_grant_dm;
    logic        w_grant_if;
    logic        w_expire;
    logic        w_ack;
    logic        w_abort;
    logic        w_done;

    assign w_busy     = (r_state != IDLE);
    assign w_owner    = (r_state == FETCH) ? OWN_IF : OWN_DM;
    assign w_starved  = if_req && (r_starve == SW'(STARVE_LIMIT));
    assign w_grant_dm = !w_busy && dm_req && !w_starved;
    assign w_grant_if = !w_busy && !w_grant_dm && if_req;

    // An ack in the expiry cycle counts as a normal completion; reset suppresses both.
    assign w_ack   = w_busy && mem_ack && !rst;
    assign w_abort = w_busy && w_expire && !mem_ack && !rst;
    assign w_done  = w_ack || w_abort;

    assign if_valid = w_done && (w_owner == OWN_IF);
    assign dm_valid = w_done && (w_owner == OWN_DM);
    assign if_rdata = (w_ack && w_owner == OWN_IF) ? mem_rdata : '0;
    assign dm_rdata = (w_ack && w_owner == OWN_DM && !r_we) ? mem_rdata : '0;
    assign bus_err  = w_abort;

    assign stall_if = if_req && !if_valid;
    assign stall_mw = dm_req && !dm_valid;

    assign mem_req   = w_busy;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_grant_dm || w_grant_if),
        .i_en     (w_busy),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_starve <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_dm) begin
                        r_state <= DATA;
                        r_we    <= dm_we;
                        r_addr  <= dm_addr;
                        r_wdata <= dm_wdata;
                        r_be    <= dm_be;
                        if (!if_req) begin
                            r_starve <= '0;
                        end else if (r_starve != SW'(STARVE_LIMIT)) begin
                            r_starve <= r_starve + SW'(1);
                        end
                    end else if (w_grant_if) begin
                        r_state  <= FETCH;
                        r_we     <= 1'b0;
                        r_addr   <= if_addr;
                        r_wdata  <= '0;
                        r_be     <= FETCH_BE;
                        r_starve <= '0;
                    end
                end
                FETCH, DATA: begin
                    if (mem_ack || w_expire) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
